// File: rtl/apb_rr_master_pkg.sv
// Shared types and constants for the two-port APB4 round-robin master.
// The optional ACCESS timeout is enabled by defining APB_RR_MASTER_TIMEOUT_EN.
package apb_rr_master_pkg;

    localparam int APB_ADDR_W             = 16;
    localparam int APB_DATA_W             = 32;
    localparam int APB_STRB_W             = 4;
    localparam int TIMEOUT_CYCLES_DEFAULT = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_t;

    typedef struct packed {
        logic                  write;
        logic [APB_ADDR_W-1:0] addr;
        logic [APB_DATA_W-1:0] wdata;
        logic [APB_STRB_W-1:0] wstrb;
        logic [2:0]            prot;
    } apb_cmd_t;

    // APB4 reads must present zero write data and zero strobes.
    function automatic apb_cmd_t sanitize_cmd(input apb_cmd_t c);
        apb_cmd_t r;
        r = c;
        if (!c.write) begin
            r.wdata = '0;
            r.wstrb = '0;
        end else begin
            r.wdata = c.wdata;
            r.wstrb = c.wstrb;
        end
        return r;
    endfunction

endpackage

// File: rtl/apb_rr_master_chk.sv
// Protocol checker for the APB master: handshake one-hotness and phase ordering.
module apb_rr_master_chk (
    input logic       pclk,
    input logic       presetn,
    input logic       psel,
    input logic       penable,
    input logic [1:0] ready,
    input logic [1:0] resp_valid
);

    // penable is only meaningful while the slave is selected.
    a_enable_in_sel: assert property (@(posedge pclk) disable iff (!presetn)
        penable |-> psel) else $error("apb_rr_master_chk: penable without psel");

    // SETUP always lasts exactly one cycle.
    a_setup_one: assert property (@(posedge pclk) disable iff (!presetn)
        (psel && !penable) |=> penable) else $error("apb_rr_master_chk: SETUP not followed by ACCESS");

    a_ready_1h: assert property (@(posedge pclk) disable iff (!presetn)
        $onehot0(ready)) else $error("apb_rr_master_chk: both requesters accepted");

    a_resp_1h: assert property (@(posedge pclk) disable iff (!presetn)
        $onehot0(resp_valid)) else $error("apb_rr_master_chk: two responses at once");

    a_resp_pulse: assert property (@(posedge pclk) disable iff (!presetn)
        (|resp_valid) |=> !(|resp_valid)) else $error("apb_rr_master_chk: response longer than one cycle");

endmodule

// File: rtl/apb_rr_master_rr_arb2.sv
// Two-way round-robin grant with the last-granted register.
// A tie goes to the requester that was not granted last; last resets to 1.
module rr_arb2
    import apb_rr_master_pkg::*;
(
    input  logic       pclk,
    input  logic       presetn,
    input  logic [1:0] valid,
    input  logic       en,
    output logic [1:0] grant
);

    logic last_r;

    // Grant selection from the pending requests and the last winner.
    always_comb begin
        grant = 2'b00;
        case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_r ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    // Last-granted register, updated only when the grant is consumed.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            last_r <= 1'b1;
        end else if (en) begin
            last_r <= grant[1];
        end else begin
            last_r <= last_r;
        end
    end

endmodule

// File: rtl/apb_rr_master.sv
// Two-port APB4 master: round-robin arbitration, SETUP/ACCESS sequencing, response routing.
// Define APB_RR_MASTER_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES cycles without pready.
module apb_rr_master
    import apb_rr_master_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic                  pclk,
    input  logic                  presetn,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic                  req0_write,
    input  logic [APB_ADDR_W-1:0] req0_addr,
    input  logic [APB_DATA_W-1:0] req0_wdata,
    input  logic [APB_STRB_W-1:0] req0_wstrb,
    input  logic [2:0]            req0_prot,
    output logic                  resp0_valid,
    output logic [APB_DATA_W-1:0] resp0_rdata,
    output logic                  resp0_err,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic                  req1_write,
    input  logic [APB_ADDR_W-1:0] req1_addr,
    input  logic [APB_DATA_W-1:0] req1_wdata,
    input  logic [APB_STRB_W-1:0] req1_wstrb,
    input  logic [2:0]            req1_prot,
    output logic                  resp1_valid,
    output logic [APB_DATA_W-1:0] resp1_rdata,
    output logic                  resp1_err,
    output logic [APB_ADDR_W-1:0] paddr,
    output logic [2:0]            pprot,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [APB_DATA_W-1:0] pwdata,
    output logic [APB_STRB_W-1:0] pwstrb,
    input  logic                  pready,
    input  logic [APB_DATA_W-1:0] prdata,
    input  logic                  pslverr
);

    if (TIMEOUT_CYCLES < 2) begin : g_timeout_guard
        $error("apb_rr_master: TIMEOUT_CYCLES must be at least 2");
    end

    apb_state_t            state_r;
    apb_state_t            state_nx;
    logic [1:0]            valid_s;
    logic [1:0]            grant_s;
    logic                  accept_s;
    logic                  complete_s;
    logic                  timeout_s;
    logic                  timeout_hit_s;
    logic                  id_r;
    apb_cmd_t              cmd_s;
    logic [APB_DATA_W-1:0] resp_rdata_s;
    logic                  resp_err_s;

    assign valid_s    = {req1_valid, req0_valid};
    assign req0_ready = (state_r == ST_IDLE) & grant_s[0];
    assign req1_ready = (state_r == ST_IDLE) & grant_s[1];

    rr_arb2 u_arb (
        .pclk    (pclk),
        .presetn (presetn),
        .valid   (valid_s),
        .en      (accept_s),
        .grant   (grant_s)
    );

`ifdef APB_RR_MASTER_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] acc_cnt_r;

    // ACCESS cycle counter; it sits at zero outside ACCESS so entry always starts from 0.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            acc_cnt_r <= '0;
        end else if (state_r == ST_ACCESS) begin
            acc_cnt_r <= acc_cnt_r + CNT_W'(1);
        end else begin
            acc_cnt_r <= '0;
        end
    end

    assign timeout_hit_s = (state_r == ST_ACCESS) && (acc_cnt_r == CNT_LAST);
`else
    assign timeout_hit_s = 1'b0;
`endif

    // Command of the granted requester, with read data/strobes forced to zero.
    always_comb begin
        cmd_s = '0;
        if (grant_s[1]) begin
            cmd_s = sanitize_cmd('{write: req1_write, addr: req1_addr, wdata: req1_wdata,
                                   wstrb: req1_wstrb, prot: req1_prot});
        end else begin
            cmd_s = sanitize_cmd('{write: req0_write, addr: req0_addr, wdata: req0_wdata,
                                   wstrb: req0_wstrb, prot: req0_prot});
        end
    end

    // FSM state register.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx;
        end
    end

    // Next state plus accept/completion strobes; pready wins over a same-cycle timeout.
    always_comb begin
        state_nx   = state_r;
        accept_s   = 1'b0;
        complete_s = 1'b0;
        timeout_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (|valid_s) begin
                    accept_s = 1'b1;
                    state_nx = ST_SETUP;
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            ST_SETUP: begin
                state_nx = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (pready) begin
                    complete_s = 1'b1;
                    state_nx   = ST_IDLE;
                end else if (timeout_hit_s) begin
                    complete_s = 1'b1;
                    timeout_s  = 1'b1;
                    state_nx   = ST_IDLE;
                end else begin
                    state_nx = ST_ACCESS;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // Response payload: reads return prdata, writes and aborts return zero.
    always_comb begin
        resp_rdata_s = '0;
        resp_err_s   = 1'b0;
        if (timeout_s) begin
            resp_rdata_s = '0;
            resp_err_s   = 1'b1;
        end else if (pwrite) begin
            resp_rdata_s = '0;
            resp_err_s   = pslverr;
        end else begin
            resp_rdata_s = prdata;
            resp_err_s   = pslverr;
        end
    end

    // APB request registers and the owner of the in-flight transfer.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            paddr   <= '0;
            pprot   <= 3'd0;
            pwrite  <= 1'b0;
            pwdata  <= '0;
            pwstrb  <= '0;
            psel    <= 1'b0;
            penable <= 1'b0;
            id_r    <= 1'b0;
        end else if (accept_s) begin
            paddr   <= cmd_s.addr;
            pprot   <= cmd_s.prot;
            pwrite  <= cmd_s.write;
            pwdata  <= cmd_s.wdata;
            pwstrb  <= cmd_s.wstrb;
            psel    <= 1'b1;
            penable <= 1'b0;
            id_r    <= grant_s[1];
        end else if (state_r == ST_SETUP) begin
            penable <= 1'b1;
        end else if (complete_s) begin
            psel    <= 1'b0;
            penable <= 1'b0;
        end else begin
            psel    <= psel;
            penable <= penable;
        end
    end

    // Response registers: one-cycle valid pulse routed to the issuing requester.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            resp0_valid <= 1'b0;
            resp0_rdata <= '0;
            resp0_err   <= 1'b0;
            resp1_valid <= 1'b0;
            resp1_rdata <= '0;
            resp1_err   <= 1'b0;
        end else begin
            resp0_valid <= complete_s & ~id_r;
            resp1_valid <= complete_s & id_r;
            if (complete_s && id_r) begin
                resp1_rdata <= resp_rdata_s;
                resp1_err   <= resp_err_s;
            end else if (complete_s) begin
                resp0_rdata <= resp_rdata_s;
                resp0_err   <= resp_err_s;
            end else begin
                resp0_rdata <= resp0_rdata;
                resp1_rdata <= resp1_rdata;
            end
        end
    end

    apb_rr_master_chk u_chk (
        .pclk       (pclk),
        .presetn    (presetn),
        .psel       (psel),
        .penable    (penable),
        .ready      ({req1_ready, req0_ready}),
        .resp_valid ({resp1_valid, resp0_valid})
    );

endmodule

// File: tb/tb_apb_rr_master.sv
// Self-checking bench for apb_rr_master: stub APB slave, queue-based reference model,
// directed and randomized transfers; timeout expectations follow APB_RR_MASTER_TIMEOUT_EN.
module tb_apb_rr_master;
    import apb_rr_master_pkg::*;

    localparam int TO = 16;
    localparam logic [15:0] ERR_ADDR = 16'h00F0;

    logic        pclk = 1'b0;
    logic        presetn;
    logic        req0_valid, req0_ready, req0_write, resp0_valid, resp0_err;
    logic [15:0] req0_addr;
    logic [31:0] req0_wdata, resp0_rdata;
    logic [3:0]  req0_wstrb;
    logic [2:0]  req0_prot;
    logic        req1_valid, req1_ready, req1_write, resp1_valid, resp1_err;
    logic [15:0] req1_addr;
    logic [31:0] req1_wdata, resp1_rdata;
    logic [3:0]  req1_wstrb;
    logic [2:0]  req1_prot;
    logic [15:0] paddr;
    logic [2:0]  pprot;
    logic        psel, penable, pwrite, pready, pslverr;
    logic [31:0] pwdata, prdata;
    logic [3:0]  pwstrb;

    logic        stall;
    logic [31:0] slv_mem [4];

    int          checks = 0;
    int          errors = 0;
    logic        last_m;
    logic [31:0] ref_mem [int];
    apb_cmd_t    q0 [$];
    apb_cmd_t    q1 [$];

    always #5 pclk = ~pclk;

    apb_rr_master #(.TIMEOUT_CYCLES(TO)) dut (
        .pclk(pclk), .presetn(presetn),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_write(req0_write),
        .req0_addr(req0_addr), .req0_wdata(req0_wdata), .req0_wstrb(req0_wstrb),
        .req0_prot(req0_prot), .resp0_valid(resp0_valid), .resp0_rdata(resp0_rdata),
        .resp0_err(resp0_err),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_write(req1_write),
        .req1_addr(req1_addr), .req1_wdata(req1_wdata), .req1_wstrb(req1_wstrb),
        .req1_prot(req1_prot), .resp1_valid(resp1_valid), .resp1_rdata(resp1_rdata),
        .resp1_err(resp1_err),
        .paddr(paddr), .pprot(pprot), .psel(psel), .penable(penable), .pwrite(pwrite),
        .pwdata(pwdata), .pwstrb(pwstrb), .pready(pready), .prdata(prdata), .pslverr(pslverr)
    );

    // Stub slave: four words at 0x0..0xC, pready one cycle after ACCESS starts, error at ERR_ADDR.
    always @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            pready  <= 1'b0;
            prdata  <= 32'h0;
            pslverr <= 1'b0;
            for (int i = 0; i < 4; i++) slv_mem[i] <= 32'h0;
        end else begin
            pready  <= 1'b0;
            pslverr <= 1'b0;
            prdata  <= stall ? 32'hBAD0BAD0 : 32'h0;
            if (psel && penable && !pready && !stall) begin
                pready <= 1'b1;
                if (paddr == ERR_ADDR) begin
                    pslverr <= 1'b1;
                end else if (paddr[15:4] == 12'h000) begin
                    if (pwrite) begin
                        for (int b = 0; b < 4; b++)
                            if (pwstrb[b]) slv_mem[paddr[3:2]][8*b +: 8] <= pwdata[8*b +: 8];
                    end else begin
                        prdata <= slv_mem[paddr[3:2]];
                    end
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic apb_cmd_t mk(input logic wr, input logic [15:0] a, input logic [31:0] d,
                                    input logic [3:0] s, input logic [2:0] p);
        return '{write: wr, addr: a, wdata: d, wstrb: s, prot: p};
    endfunction

    function automatic apb_cmd_t rand_cmd();
        int r;
        r = $urandom_range(0, 9);
        return mk(1'($urandom), (r < 8) ? 16'(4 * (r % 4)) : ((r == 8) ? 16'h0010 : ERR_ADDR),
                  $urandom, 4'($urandom), 3'($urandom));
    endfunction

    // Reference: a word store keyed by address; errors and unmapped addresses never store.
    function automatic void model_xfer(input apb_cmd_t c, output logic [31:0] rd, output logic err);
        logic [31:0] w;
        int a;
        a   = int'(c.addr);
        rd  = 32'h0;
        err = (c.addr == ERR_ADDR);
        w   = ref_mem.exists(a) ? ref_mem[a] : 32'h0;
        if (!err && c.addr < 16'h0010) begin
            if (c.write) begin
                for (int b = 0; b < 4; b++) if (c.wstrb[b]) w[8*b +: 8] = c.wdata[8*b +: 8];
                ref_mem[a] = w;
            end else begin
                rd = w;
            end
        end
    endfunction

    task automatic set_req(input int n, input logic v, input apb_cmd_t c);
        if (n == 0) begin
            req0_valid = v; req0_write = c.write; req0_addr = c.addr;
            req0_wdata = c.wdata; req0_wstrb = c.wstrb; req0_prot = c.prot;
        end else begin
            req1_valid = v; req1_write = c.write; req1_addr = c.addr;
            req1_wdata = c.wdata; req1_wstrb = c.wstrb; req1_prot = c.prot;
        end
    endtask

    task automatic drive_reqs();
        if (q0.size() > 0) set_req(0, 1'b1, q0[0]); else set_req(0, 1'b0, rand_cmd());
        if (q1.size() > 0) set_req(1, 1'b1, q1[0]); else set_req(1, 1'b0, rand_cmd());
    endtask

    task automatic check_all_zero(input string tag);
        logic [127:0] v;
        v = {req0_ready, req1_ready, resp0_valid, resp0_rdata, resp0_err, resp1_valid,
             resp1_rdata, resp1_err, paddr, pprot, psel, penable, pwrite, pwdata, pwstrb};
        for (int i = 0; i < 4; i++) chk($sformatf("%s_w%0d", tag, i), v[32*i +: 32], 32'h0);
    endtask

    task automatic do_reset();
        @(negedge pclk);
        presetn = 1'b0;
        last_m  = 1'b1;
        ref_mem.delete();
        @(negedge pclk);
        presetn = 1'b1;
    endtask

    // Runs both queues to completion, checking grants, APB phases and responses every cycle.
    task automatic run_queues(input int budget);
        int          t = 0;
        int          acc_t = 0;
        int          ph;
        bit          busy = 1'b0;
        logic        id_o = 1'b0;
        logic [1:0]  g;
        apb_cmd_t    c_o = '0;
        logic [31:0] exp_rd = 32'h0;
        logic        exp_err = 1'b0;
        while ((q0.size() > 0 || q1.size() > 0 || busy) && t < budget) begin
            @(negedge pclk);
            drive_reqs();
            #1;
            t++;
            if (busy) begin
                ph = t - acc_t;
                if (ph == 1) begin
                    chk("setup_psel", 32'(psel), 32'd1);
                    chk("setup_penable", 32'(penable), 32'd0);
                    chk("paddr", 32'(paddr), 32'(c_o.addr));
                    chk("pwrite", 32'(pwrite), 32'(c_o.write));
                    chk("pwdata", pwdata, c_o.write ? c_o.wdata : 32'h0);
                    chk("pwstrb", 32'(pwstrb), c_o.write ? 32'(c_o.wstrb) : 32'h0);
                    chk("pprot", 32'(pprot), 32'(c_o.prot));
                end else if (ph < 4) begin
                    chk("access_sel_en", 32'({psel, penable}), 32'd3);
                end
                if (ph == 4) begin
                    chk("done_sel_en", 32'({psel, penable}), 32'd0);
                    chk("resp_valid", 32'({resp1_valid, resp0_valid}), id_o ? 32'd2 : 32'd1);
                    chk("resp_rdata", id_o ? resp1_rdata : resp0_rdata, exp_rd);
                    chk("resp_err", 32'(id_o ? resp1_err : resp0_err), 32'(exp_err));
                    busy = 1'b0;
                end else begin
                    chk("resp_quiet", 32'({resp1_valid, resp0_valid}), 32'd0);
                end
            end else begin
                chk("resp_idle", 32'({resp1_valid, resp0_valid}), 32'd0);
            end
            g = 2'b00;
            if (!busy) begin
                if (q0.size() > 0 && q1.size() > 0) g = last_m ? 2'b01 : 2'b10;
                else if (q0.size() > 0)             g = 2'b01;
                else if (q1.size() > 0)             g = 2'b10;
                else                                g = 2'b00;
            end
            chk("ready", 32'({req1_ready, req0_ready}), 32'(g));
            if (g != 2'b00) begin
                id_o   = g[1];
                c_o    = g[1] ? q1.pop_front() : q0.pop_front();
                model_xfer(c_o, exp_rd, exp_err);
                last_m = id_o;
                busy   = 1'b1;
                acc_t  = t;
            end
        end
        chk("run_budget", 32'(t < budget), 32'd1);
    endtask

    // Presents one command and returns just after it is accepted.
    task automatic issue(input int n, input apb_cmd_t c);
        int w = 0;
        @(negedge pclk);
        set_req(n, 1'b1, c);
        #1;
        while (!(n == 1 ? req1_ready : req0_ready) && w < 10) begin
            @(negedge pclk);
            #1;
            w++;
        end
        chk("issue_ready", 32'(w < 10), 32'd1);
        last_m = (n == 1);
        @(negedge pclk);
        set_req(0, 1'b0, rand_cmd());
        set_req(1, 1'b0, rand_cmd());
    endtask

    initial begin
        int   k;
        int   n;
        bit   bad;
        presetn = 1'b1;
        stall   = 1'b0;
        last_m  = 1'b1;
        set_req(0, 1'b0, '0);
        set_req(1, 1'b0, '0);
        #1 presetn = 1'b0;
        repeat (3) @(negedge pclk);
        check_all_zero("reset");
        presetn = 1'b1;

        // Requester 0 writes then reads back.
        q0.push_back(mk(1'b1, 16'h0004, 32'hDEADBEEF, 4'hF, 3'd0));
        q0.push_back(mk(1'b0, 16'h0004, 32'h12345678, 4'hA, 3'd2));
        run_queues(40);

        // Both valid from reset: strict alternation starting with requester 0.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            q0.push_back(mk(1'b1, 16'h0000, $urandom, 4'hF, 3'd1));
            q1.push_back(mk(1'b1, 16'h0008, $urandom, 4'hF, 3'd5));
        end
        run_queues(60);

        // Unmapped read, then slave error on write and read.
        q1.push_back(mk(1'b0, 16'h0010, 32'h0, 4'h0, 3'd0));
        run_queues(20);
        q0.push_back(mk(1'b1, ERR_ADDR, 32'hFFFF0000, 4'hF, 3'd0));
        q1.push_back(mk(1'b0, ERR_ADDR, 32'h0, 4'h0, 3'd7));
        run_queues(30);

        // Randomized batches.
        for (int b = 0; b < 5; b++) begin
            n = $urandom_range(3, 6);
            k = $urandom_range(0, 2);
            for (int i = 0; i < n; i++) begin
                if (k == 0 || (k == 2 && $urandom_range(0, 1) == 0)) q0.push_back(rand_cmd());
                else q1.push_back(rand_cmd());
            end
            run_queues(200);
        end

        // Slave never answers.
        stall = 1'b1;
        issue(1, mk(1'b0, 16'h0004, 32'h0, 4'h0, 3'd0));
`ifdef APB_RR_MASTER_TIMEOUT_EN
        k = 1;
        #1;
        while (!resp1_valid && k < 40) begin
            @(negedge pclk);
            #1;
            k++;
        end
        chk("timeout_latency", 32'(k), 32'(TO + 2));
        chk("timeout_err", 32'(resp1_err), 32'd1);
        chk("timeout_rdata", resp1_rdata, 32'h0);
        chk("timeout_idle", 32'({psel, penable, resp0_valid}), 32'd0);
        stall = 1'b0;
`else
        bad = 1'b0;
        #1;
        for (int i = 1; i <= 110; i++) begin
            if (psel !== 1'b1 || penable !== (i >= 2) || resp0_valid !== 1'b0 || resp1_valid !== 1'b0)
                bad = 1'b1;
            @(negedge pclk);
            #1;
        end
        chk("hang_holds", 32'(bad), 32'd0);
        stall = 1'b0;
        do_reset();
`endif

        // Reset in the middle of ACCESS.
        q1.push_back(mk(1'b1, 16'h000C, 32'hA5A5A5A5, 4'hF, 3'd3));
        run_queues(20);
        stall = 1'b1;
        issue(0, mk(1'b1, 16'h0008, 32'hCAFEF00D, 4'hF, 3'd0));
        repeat (3) @(negedge pclk);
        #2 presetn = 1'b0;
        last_m = 1'b1;
        ref_mem.delete();
        #1 check_all_zero("midreset");
        stall = 1'b0;
        @(negedge pclk);
        presetn = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge pclk);
            #1;
            if (resp0_valid !== 1'b0 || resp1_valid !== 1'b0 || psel !== 1'b0) bad = 1'b1;
        end
        chk("no_resp_after_reset", 32'(bad), 32'd0);
        q0.push_back(mk(1'b0, 16'h0008, 32'h0, 4'h0, 3'd0));
        q1.push_back(mk(1'b1, 16'h0008, 32'h0BADC0DE, 4'h3, 3'd1));
        q0.push_back(mk(1'b0, 16'h0008, 32'h0, 4'h0, 3'd0));
        run_queues(40);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/apb_rr_master.md
# apb_rr_master

Two-port APB4 master that shares one APB bus between two requesters with round-robin arbitration. It sequences each accepted command through the APB SETUP and ACCESS phases and returns read data and error status to the requester that issued it. It sits in front of the register slave (`dut_reg`, 16-bit `paddr`, 32-bit data) and drives its APB inputs directly.

## Interface
- `TIMEOUT_CYCLES`, default 16: maximum number of ACCESS cycles before the transfer is aborted. Used only when the timeout feature is compiled in. Minimum value is 2.
- `pclk` in 1: clock.
- `presetn` in 1: asynchronous, active-low reset.
- `reqN_valid` in 1 (N=0,1): requester N has a command pending.
- `reqN_ready` out 1: one-cycle pulse; the command is accepted on this edge.
- `reqN_write` in 1: 1 = write, 0 = read.
- `reqN_addr` in 16: byte address.
- `reqN_wdata` in 32: write data.
- `reqN_wstrb` in 4: byte strobes.
- `reqN_prot` in 3: protection attribute.
- `respN_valid` out 1: one-cycle pulse; the response for requester N is valid.
- `respN_rdata` out 32: read data. 0 for writes and for aborted transfers.
- `respN_err` out 1: the slave returned `pslverr`, or the transfer timed out.
- `paddr` out 16, `pprot` out 3, `psel` out 1, `penable` out 1, `pwrite` out 1, `pwdata` out 32, `pwstrb` out 4: APB request signals. All are registered.
- `pready` in 1, `prdata` in 32, `pslverr` in 1: APB completion signals.

## Operation
- FSM states: IDLE, SETUP, ACCESS.
- **IDLE**
  - If any `reqN_valid` is high, grant one requester. `reqN_ready` = (state==IDLE) & grant[N]; it is combinational from the registered state.
  - On the accepting edge:
    - latch the command into the APB registers;
    - store the grant ID;
    - set `psel`=1, `penable`=0;
    - go to SETUP.
- **SETUP**
  - Always lasts one cycle.
  - Set `penable`=1 and go to ACCESS.
- **ACCESS**
  - Wait for `pready`=1. `pready` is sampled only in ACCESS and ignored in IDLE and SETUP.
  - On completion:
    - capture `prdata` (reads only) and `pslverr`;
    - set `psel`=`penable`=0;
    - go to IDLE;
    - set `resp<id>_valid`=1 for the following cycle.
- **Arbitration**
  - The `last` register holds the ID of the last granted requester and updates on accept.
  - If both requesters are valid, grant the one ≠ `last`. If only one is valid, grant it.
  - `last` resets to 1, so requester 0 wins the first tie.
- **Reads:** `pwdata`=0 and `pwstrb`=0, as APB4 requires.
- **Requester inputs** may change freely after `reqN_ready` because the command is latched.
- **Back-to-back transfers:** a new accept can occur in the same cycle that the previous `respN_valid` is high.
- **Reset mid-transfer:** all state clears immediately and `psel`/`penable` drop. No response is issued for the in-flight command.

## Timing
- Accept at edge of cycle T.
- `psel` high from T+1; `penable` high from T+2.
- With `dut_reg` (`pready` is registered in the slave), `pready`=1 in T+3.
- `psel`/`penable` low and `respN_valid` high in T+4.
- Throughput is 4 cycles per transfer against `dut_reg`. Minimum latency is 3 cycles if `pready` is high in the first ACCESS cycle.
- Reset values are 0 for every output, including `reqN_ready` and `respN_*`. FSM resets to IDLE, `last` to 1.

## Configuration
- Macro: `APB_RR_MASTER_TIMEOUT_EN`.
- **Defined**
  - An ACCESS counter of width $clog2(`TIMEOUT_CYCLES`) clears on entry to ACCESS.
  - If `pready` is still 0 in the `TIMEOUT_CYCLES`-th ACCESS cycle, the transfer completes with `respN_err`=1 and `respN_rdata`=0. ACCESS therefore lasts exactly `TIMEOUT_CYCLES` cycles.
  - If `pready`=1 in that same cycle, the completion is normal.
- **Not defined:** no counter exists; ACCESS waits indefinitely.

## Structure
- Package `apb_rr_master_pkg`:
  - state enum typedef;
  - command struct (write, addr, wdata, wstrb, prot);
  - constants `APB_ADDR_W`=16, `APB_DATA_W`=32, `APB_STRB_W`=4;
  - default `TIMEOUT_CYCLES`.
- Sub-module `rr_arb2`: 2-way round-robin grant logic plus the `last` register, with enable = accept.

## Test plan
- Requester 0 writes `0xDEADBEEF` to `0x0004`, then reads `0x0004` → `psel` in T+1, `penable` in T+2, `resp0_valid` in T+4 with err=0; the read returns `0xDEADBEEF` and `pwstrb`=0 during the read.
- Both requesters are valid from reset, each with 3 writes to `0x0000`/`0x0008` → grants alternate 0,1,0,1,0,1 with no idle cycle between a response and the next accept.
- Requester 1 reads unmapped address `0x0010` → `resp1_rdata`=0, err=0; requester 0 sees no response.
- Stub slave holds `pready`=0, macro defined → abort after 16 ACCESS cycles with `resp_err`=1 and `rdata`=0. Macro undefined → `psel`/`penable` stay high for 100+ cycles.
- `presetn` is asserted during ACCESS → all outputs are 0 asynchronously, no `respN_valid` is issued, and after release the next request completes normally.
- Slave returns `pslverr`=1 with `pready` → `respN_err`=1 and the FSM returns to IDLE.
